// File: rtl/sa_seq_pkg.sv
// sa_seq_pkg: shared types and constants for the SA batch sequencer.
// Widths of the SA data path and result flag bit positions.
package sa_seq_pkg;

    localparam int TGT_W = 10;
    localparam int X_W   = 8;

    localparam int FLG_TO  = 1;
    localparam int FLG_TOL = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_DONE,
        S_WAIT_LOW,
        S_GAP,
        S_FINISH
    } state_t;

endpackage

// File: rtl/sa_tol_check.sv
// sa_tol_check: flags a search result whose y strays too far from target.
// Uses an 11-bit signed difference so the full 10-bit range is covered.
module sa_tol_check
    import sa_seq_pkg::*;
#(
    parameter int TOL = 4
) (
    input  logic [TGT_W-1:0] y,
    input  logic [TGT_W-1:0] target,
    output logic             out_of_tol
);

    logic signed [TGT_W:0] diff;
    logic        [TGT_W:0] mag;

    // |y - target| compared against the allowed tolerance
    always_comb begin
        diff       = $signed({1'b0, y}) - $signed({1'b0, target});
        mag        = diff[TGT_W] ? $unsigned(-diff) : $unsigned(diff);
        out_of_tol = int'(mag) > TOL;
    end

endmodule

// File: rtl/sa_sequencer.sv
// sa_sequencer: batch initiator for the SA search block.
// Launches one search per table entry, captures x/y and flags errors.
module sa_sequencer
    import sa_seq_pkg::*;
#(
    parameter  int DEPTH   = 8,
    parameter  int GAP     = 2,
    parameter  int TIMEOUT = 64,
    parameter  int TOL     = 4,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [TGT_W-1:0] wr_data,
    input  logic             run,
    input  logic [4:0]       num,
    output logic             busy,
    output logic             finished,
    output logic [3:0]       err_cnt,
    input  logic [AW-1:0]    rd_addr,
    output logic [X_W-1:0]   rd_x,
    output logic [TGT_W-1:0] rd_y,
    output logic [1:0]       rd_flags,
    output logic [TGT_W-1:0] target,
    output logic             start,
    input  logic             done,
    input  logic [X_W-1:0]   x,
    input  logic [TGT_W-1:0] y
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(GAP + 2);

    state_t state_q, state_d;

    logic [AW-1:0]    idx_q;
    logic [4:0]       num_q;
    logic [TW-1:0]    tmr_q;
    logic [GW-1:0]    gcnt_q;
    logic [TGT_W-1:0] tgt_q;
    logic [3:0]       err_q;

    logic [TGT_W-1:0] tbl   [DEPTH];
    logic [X_W-1:0]   res_x [DEPTH];
    logic [TGT_W-1:0] res_y [DEPTH];
    logic [1:0]       res_f [DEPTH];

    logic [4:0] eff_num;
    logic       last;
    logic       tmr_end;
    logic       gap_end;
    logic       oot;
    logic [1:0] new_f;
    logic       go;
    logic       adv;
    logic       cap_ok;
    logic       cap_to;

    assign eff_num = (num > 5'(DEPTH)) ? 5'(DEPTH) : num;
    assign last    = (5'(idx_q) == num_q - 5'd1);
    assign tmr_end = int'(tmr_q) >= TIMEOUT - 1;
    assign gap_end = int'(gcnt_q) >= GAP - 1;

    assign busy     = (state_q != S_IDLE);
    assign finished = (state_q == S_FINISH);
    assign start    = (state_q == S_LAUNCH);
    assign target   = start ? tbl[idx_q] : tgt_q;
    assign err_cnt  = err_q;

    assign rd_x     = res_x[rd_addr];
    assign rd_y     = res_y[rd_addr];
    assign rd_flags = res_f[rd_addr];

    sa_tol_check #(
        .TOL(TOL)
    ) u_tol (
        .y         (y),
        .target    (tgt_q),
        .out_of_tol(oot)
    );

    // flags recorded for the entry being closed this cycle
    always_comb begin
        new_f = '0;
        if (cap_to) begin
            new_f[FLG_TO] = 1'b1;
        end else begin
            new_f[FLG_TOL] = oot;
        end
    end

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state decode and per-cycle control strobes
    always_comb begin
        state_d = state_q;
        go      = 1'b0;
        adv     = 1'b0;
        cap_ok  = 1'b0;
        cap_to  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (run) begin
                    if (eff_num != 5'd0) begin
                        go      = 1'b1;
                        state_d = S_LAUNCH;
                    end else begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (done) begin
                    cap_ok  = 1'b1;
                    state_d = S_WAIT_LOW;
                end else if (tmr_end) begin
                    cap_to  = 1'b1;
                    state_d = S_GAP;
                end
            end
            S_WAIT_LOW: begin
                if (!done) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_end) begin
                    if (last) begin
                        state_d = S_FINISH;
                    end else begin
                        adv     = 1'b1;
                        state_d = S_LAUNCH;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // batch bookkeeping: index, counters, held target, error count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q  <= '0;
            num_q  <= '0;
            tmr_q  <= '0;
            gcnt_q <= '0;
            tgt_q  <= '0;
            err_q  <= '0;
        end else begin
            if (go) begin
                idx_q <= '0;
                num_q <= eff_num;
                err_q <= '0;
            end else if (adv) begin
                idx_q <= idx_q + 1'b1;
            end
            if (start) begin
                tgt_q <= tbl[idx_q];
            end
            tmr_q  <= (state_q == S_WAIT_DONE) ? tmr_q + 1'b1 : '0;
            gcnt_q <= (state_q == S_GAP) ? gcnt_q + 1'b1 : '0;
            if ((cap_ok || cap_to) && (new_f != 2'b00) && (err_q != 4'hF)) begin
                err_q <= err_q + 4'd1;
            end
        end
    end

    // target table, writable only between batches
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl[i] <= '0;
            end
        end else if (wr_en && (state_q == S_IDLE)) begin
            tbl[wr_addr] <= wr_data;
        end
    end

    // result buffer, one capture per launched search
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                res_x[i] <= '0;
                res_y[i] <= '0;
                res_f[i] <= '0;
            end
        end else if (cap_ok) begin
            res_x[idx_q] <= x;
            res_y[idx_q] <= y;
            res_f[idx_q] <= new_f;
        end else if (cap_to) begin
            res_x[idx_q] <= '0;
            res_y[idx_q] <= '0;
            res_f[idx_q] <= new_f;
        end
    end

endmodule

// File: tb/tb_sa_sequencer.sv
// tb_sa_sequencer: randomized self-checking bench with an SA responder.
// Expected results come from a per-entry model of the batch rules.
module tb_sa_sequencer;

    localparam int DEPTH   = 16;
    localparam int GAP     = 2;
    localparam int TIMEOUT = 64;
    localparam int TOL     = 4;

    logic       clk, reset, wr_en, run, busy, finished, start, done;
    logic [3:0] wr_addr, rd_addr, err_cnt;
    logic [9:0] wr_data, rd_y, target, y;
    logic [4:0] num;
    logic [7:0] rd_x, x;
    logic [1:0] rd_flags;

    int nt, nf, fin_n;
    int cyc = 0;
    int st_tgt[$], st_cyc[$], fall_cyc[$];
    int sb, fb, f0;
    int m_off, m_len, m_silent;
    int tbl_m[DEPTH], rx_m[DEPTH], ry_m[DEPTH], rf_m[DEPTH];
    int exp_n, exp_err;

    sa_sequencer #(
        .DEPTH(DEPTH), .GAP(GAP), .TIMEOUT(TIMEOUT), .TOL(TOL)
    ) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .run(run), .num(num), .busy(busy),
        .finished(finished), .err_cnt(err_cnt), .rd_addr(rd_addr),
        .rd_x(rd_x), .rd_y(rd_y), .rd_flags(rd_flags), .target(target),
        .start(start), .done(done), .x(x), .y(y)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // SA responder: done 10 cycles after start, held m_len cycles
    initial begin
        int pend, hold, ptgt;
        pend = 0; hold = 0; ptgt = 0;
        done = 1'b0; x = '0; y = '0;
        forever begin
            @(posedge clk); #2;
            if (!reset) begin
                pend = 0; hold = 0; done = 1'b0;
            end else if (hold > 0) begin
                hold--;
                if (hold == 0) done = 1'b0;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    done = 1'b1;
                    x = 8'(ptgt >> 2);
                    y = 10'(ptgt + m_off);
                    hold = m_len;
                end
            end else if (start && m_silent == 0) begin
                pend = 10;
                ptgt = int'(target);
            end
        end
    end

    // event log: starts, done falling edges, finished pulses
    initial begin
        logic pd;
        pd = 1'b0;
        fin_n = 0;
        forever begin
            @(negedge clk);
            if (start) begin
                st_tgt.push_back(int'(target));
                st_cyc.push_back(cyc);
            end
            if (finished) fin_n++;
            if (pd && !done) fall_cyc.push_back(cyc);
            pd = done;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: sim time exceeded, want batch completion");
        $fatal(1, "watchdog");
    end

    function automatic void model_batch(input int n);
        int cnt = 0;
        int d;
        exp_n = (n > DEPTH) ? DEPTH : n;
        for (int i = 0; i < exp_n; i++) begin
            if (m_silent != 0) begin
                rx_m[i] = 0; ry_m[i] = 0; rf_m[i] = 2;
            end else begin
                rx_m[i] = tbl_m[i] / 4;
                ry_m[i] = (tbl_m[i] + m_off) & 1023;
                d = ry_m[i] - tbl_m[i];
                if (d < 0) d = -d;
                rf_m[i] = (d > TOL) ? 1 : 0;
            end
            if (rf_m[i] != 0) cnt++;
        end
        if (exp_n > 0) exp_err = (cnt > 15) ? 15 : cnt;
    endfunction

    task automatic wr(input int a, input int d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 4'(a); wr_data = 10'(d);
        @(negedge clk);
        wr_en = 1'b0;
        tbl_m[a] = d;
    endtask

    task automatic do_run(input int n);
        sb = st_tgt.size(); fb = fall_cyc.size(); f0 = fin_n;
        @(negedge clk);
        num = 5'(n); run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        for (int k = 0; k < 4000 && busy; k++) @(negedge clk);
        @(negedge clk);
        nt++;
        if (busy !== 1'b0) begin
            nf++; $display("FAIL batch_end: busy=%0b want 0", busy);
        end
        model_batch(n);
    endtask

    task automatic test_reset;
        @(negedge clk); #1;
        nt++;
        if ({start, busy, finished, target, err_cnt} !== '0) begin
            nf++;
            $display("FAIL rst_out: st=%0b bz=%0b fin=%0b tgt=%0d err=%0d want 0",
                     start, busy, finished, target, err_cnt);
        end
        @(negedge clk); reset = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk); rd_addr = 4'(i); #1;
            nt++;
            if ({rd_x, rd_y, rd_flags} !== '0) begin
                nf++;
                $display("FAIL rst_rd[%0d]: got %0d/%0d/%0d want 0/0/0", i, rd_x, rd_y, rd_flags);
            end
        end
    endtask

    task automatic test_basic;
        m_silent = 0; m_off = -2; m_len = 2;
        wr(0, 550); wr(1, 800);
        do_run(2);
        nt++;
        if (st_tgt.size() - sb != 2 || fin_n - f0 != 1) begin
            nf++;
            $display("FAIL basic_cnt: starts=%0d fin=%0d want 2/1", st_tgt.size() - sb, fin_n - f0);
        end
        for (int i = 0; i < 2 && sb + i < st_tgt.size(); i++) begin
            nt++;
            if (st_tgt[sb + i] != tbl_m[i]) begin
                nf++; $display("FAIL basic_tgt[%0d]: got %0d want %0d", i, st_tgt[sb + i], tbl_m[i]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); rd_addr = 4'(i); #1;
            nt++;
            if (rd_x !== 8'(rx_m[i]) || rd_y !== 10'(ry_m[i]) || rd_flags !== 2'(rf_m[i])) begin
                nf++;
                $display("FAIL basic_res[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d",
                         i, rd_x, rd_y, rd_flags, rx_m[i], ry_m[i], rf_m[i]);
            end
        end
        nt++;
        if (err_cnt !== 4'(exp_err)) begin
            nf++; $display("FAIL basic_err: got %0d want %0d", err_cnt, exp_err);
        end
    endtask

    task automatic test_tol;
        int offs[4];
        offs[0] = 5; offs[1] = -4; offs[2] = 4; offs[3] = -5;
        m_silent = 0; m_len = 2;
        wr(0, 550);
        for (int k = 0; k < 4; k++) begin
            m_off = offs[k];
            do_run(1);
            rd_addr = 4'd0; #1;
            nt++;
            if (rd_flags !== 2'(rf_m[0]) || err_cnt !== 4'(exp_err) || rd_y !== 10'(ry_m[0])) begin
                nf++;
                $display("FAIL tol[%0d]: flags=%0d err=%0d y=%0d want %0d/%0d/%0d",
                         offs[k], rd_flags, err_cnt, rd_y, rf_m[0], exp_err, ry_m[0]);
            end
        end
    endtask

    task automatic test_random;
        int n;
        m_silent = 0;
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if ($urandom_range(0, 1) == 1) wr(i, int'($urandom_range(16, 1000)));
            end
            n = int'($urandom_range(1, DEPTH));
            m_off = int'($urandom_range(0, 16)) - 8;
            m_len = int'($urandom_range(1, 4));
            do_run(n);
            nt++;
            if (st_tgt.size() - sb != exp_n || fin_n - f0 != 1 || err_cnt !== 4'(exp_err)) begin
                nf++;
                $display("FAIL rand%0d_cnt: starts=%0d fin=%0d err=%0d want %0d/1/%0d",
                         it, st_tgt.size() - sb, fin_n - f0, err_cnt, exp_n, exp_err);
            end
            for (int i = 0; i < exp_n && sb + i < st_tgt.size(); i++) begin
                nt++;
                if (st_tgt[sb + i] != tbl_m[i]) begin
                    nf++; $display("FAIL rand%0d_tgt[%0d]: got %0d want %0d", it, i, st_tgt[sb + i], tbl_m[i]);
                end
            end
            for (int i = 0; i < exp_n; i++) begin
                @(negedge clk); rd_addr = 4'(i); #1;
                nt++;
                if (rd_x !== 8'(rx_m[i]) || rd_y !== 10'(ry_m[i]) || rd_flags !== 2'(rf_m[i])) begin
                    nf++;
                    $display("FAIL rand%0d_res[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d",
                             it, i, rd_x, rd_y, rd_flags, rx_m[i], ry_m[i], rf_m[i]);
                end
            end
        end
    endtask

    task automatic test_timeout;
        m_silent = 1;
        do_run(2);
        nt++;
        if (st_tgt.size() - sb != 2 ||
            (st_tgt.size() - sb == 2 && st_cyc[sb + 1] - st_cyc[sb] != TIMEOUT + GAP + 1)) begin
            nf++;
            $display("FAIL to_restart: starts=%0d want 2 spaced %0d", st_tgt.size() - sb, TIMEOUT + GAP + 1);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); rd_addr = 4'(i); #1;
            nt++;
            if (rd_x !== 8'd0 || rd_y !== 10'd0 || rd_flags !== 2'(rf_m[i])) begin
                nf++;
                $display("FAIL to_res[%0d]: got %0d/%0d/%0d want 0/0/%0d", i, rd_x, rd_y, rd_flags, rf_m[i]);
            end
        end
        for (int i = 0; i < DEPTH; i++) wr(i, int'($urandom_range(16, 1000)));
        do_run(16);
        nt++;
        if (st_tgt.size() - sb != 16 || fin_n - f0 != 1 || err_cnt !== 4'(exp_err)) begin
            nf++;
            $display("FAIL to_sat: starts=%0d fin=%0d err=%0d want 16/1/%0d",
                     st_tgt.size() - sb, fin_n - f0, err_cnt, exp_err);
        end
    endtask

    task automatic test_num;
        m_silent = 0; m_off = 3; m_len = 1;
        sb = st_tgt.size();
        @(negedge clk); num = 5'd0; run = 1'b1;
        @(negedge clk); run = 1'b0;
        nt++;
        if (finished !== 1'b1 || start !== 1'b0) begin
            nf++; $display("FAIL num0_fin: fin=%0b st=%0b want 1/0", finished, start);
        end
        @(negedge clk);
        nt++;
        if (finished !== 1'b0 || busy !== 1'b0 || st_tgt.size() != sb) begin
            nf++;
            $display("FAIL num0_end: fin=%0b bz=%0b starts=%0d want 0/0/0", finished, busy, st_tgt.size() - sb);
        end
        do_run(20);
        nt++;
        if (st_tgt.size() - sb != DEPTH || err_cnt !== 4'(exp_err)) begin
            nf++;
            $display("FAIL num20: starts=%0d err=%0d want %0d/%0d", st_tgt.size() - sb, err_cnt, DEPTH, exp_err);
        end
        for (int i = 0; i < exp_n; i++) begin
            @(negedge clk); rd_addr = 4'(i); #1;
            nt++;
            if (rd_x !== 8'(rx_m[i]) || rd_y !== 10'(ry_m[i]) || rd_flags !== 2'(rf_m[i])) begin
                nf++;
                $display("FAIL num20_res[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d",
                         i, rd_x, rd_y, rd_flags, rx_m[i], ry_m[i], rf_m[i]);
            end
        end
    endtask

    task automatic test_busy_ignore;
        m_silent = 0; m_off = 0; m_len = 20;
        wr(0, 300); wr(1, 400);
        sb = st_tgt.size(); fb = fall_cyc.size(); f0 = fin_n;
        @(negedge clk); num = 5'd2; run = 1'b1;
        @(negedge clk); run = 1'b0;
        repeat (4) @(negedge clk);
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 10'd999; run = 1'b1; num = 5'd5;
        @(negedge clk); wr_en = 1'b0; run = 1'b0;
        for (int k = 0; k < 4000 && busy; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        model_batch(2);
        nt++;
        if (busy !== 1'b0 || fin_n - f0 != 1 || st_tgt.size() - sb != 2 || err_cnt !== 4'(exp_err)) begin
            nf++;
            $display("FAIL busy_ign: bz=%0b fin=%0d starts=%0d err=%0d want 0/1/2/%0d",
                     busy, fin_n - f0, st_tgt.size() - sb, err_cnt, exp_err);
        end
        nt++;
        if (fall_cyc.size() <= fb || st_tgt.size() - sb < 2 ||
            st_cyc[sb + 1] - fall_cyc[fb] != GAP + 1) begin
            nf++;
            $display("FAIL long_done_gap: falls=%0d starts=%0d want gap %0d",
                     fall_cyc.size() - fb, st_tgt.size() - sb, GAP + 1);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); rd_addr = 4'(i); #1;
            nt++;
            if (rd_x !== 8'(rx_m[i]) || rd_y !== 10'(ry_m[i]) || rd_flags !== 2'(rf_m[i])) begin
                nf++;
                $display("FAIL busy_res[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d",
                         i, rd_x, rd_y, rd_flags, rx_m[i], ry_m[i], rf_m[i]);
            end
        end
        m_len = 2;
        do_run(1);
        nt++;
        if (st_tgt.size() - sb != 1 || st_tgt[sb] != tbl_m[0]) begin
            nf++; $display("FAIL busy_wr: starts=%0d want 1 with target %0d", st_tgt.size() - sb, tbl_m[0]);
        end
    endtask

    task automatic test_reset_mid;
        m_silent = 1;
        wr(0, 700); wr(1, 100);
        @(negedge clk); num = 5'd3; run = 1'b1;
        @(negedge clk); run = 1'b0;
        repeat (5) @(negedge clk);
        nt++;
        if (busy !== 1'b1 || target !== 10'd700) begin
            nf++; $display("FAIL mid_pre: bz=%0b tgt=%0d want 1/700", busy, target);
        end
        reset = 1'b0; #1;
        nt++;
        if (start !== 1'b0 || busy !== 1'b0 || target !== 10'd0 || err_cnt !== 4'd0) begin
            nf++;
            $display("FAIL mid_rst: st=%0b bz=%0b tgt=%0d err=%0d want 0", start, busy, target, err_cnt);
        end
        for (int i = 0; i < DEPTH; i++) begin
            tbl_m[i] = 0; rx_m[i] = 0; ry_m[i] = 0; rf_m[i] = 0;
        end
        @(negedge clk); reset = 1'b1;
        m_silent = 0; m_off = -1; m_len = 2;
        wr(0, 640); wr(1, 20);
        do_run(2);
        nt++;
        if (st_tgt.size() - sb != 2 || fin_n - f0 != 1 || err_cnt !== 4'(exp_err)) begin
            nf++;
            $display("FAIL mid_after: starts=%0d fin=%0d err=%0d want 2/1/%0d",
                     st_tgt.size() - sb, fin_n - f0, err_cnt, exp_err);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); rd_addr = 4'(i); #1;
            nt++;
            if (rd_x !== 8'(rx_m[i]) || rd_y !== 10'(ry_m[i]) || rd_flags !== 2'(rf_m[i])) begin
                nf++;
                $display("FAIL mid_res[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d",
                         i, rd_x, rd_y, rd_flags, rx_m[i], ry_m[i], rf_m[i]);
            end
        end
    endtask

    initial begin
        nt = 0; nf = 0; exp_n = 0; exp_err = 0;
        reset = 1'b0; wr_en = 1'b0; run = 1'b0;
        wr_addr = '0; wr_data = '0; num = '0; rd_addr = '0;
        m_off = 0; m_len = 2; m_silent = 0;
        for (int i = 0; i < DEPTH; i++) begin
            tbl_m[i] = 0; rx_m[i] = 0; ry_m[i] = 0; rf_m[i] = 0;
        end
        test_reset;
        test_basic;
        test_tol;
        test_random;
        test_timeout;
        test_num;
        test_busy_ignore;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", nt, nf);
        $finish;
    end

endmodule

// File: doc/sa_sequencer.md
# sa_sequencer

Host-side initiator for the successive-approximation search block (`SA`). It drives the other end of `SA`'s `start`/`done` handshake. It holds a small table of 10-bit targets and launches one `SA` search per entry. For each search it captures the resulting `x`/`y` pair, then flags timeouts and out-of-tolerance results. It sits between the host/test controller and `SA`, replacing hand-driven start pulses with a programmable batch run.

## Interface
Parameters:
- `DEPTH`, 8: target/result table entries (power of 2, max 16)
- `GAP`, 2: idle cycles between `done` falling and the next `start`
- `TIMEOUT`, 64: max cycles to wait for `done` after `start`
- `TOL`, 4: max allowed |y − target|

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `wr_en`  in  1  write target table (ignored while `busy`)
- `wr_addr`  in  log2(DEPTH)  table write index
- `wr_data`  in  10  target value
- `run`  in  1  start batch; one-cycle pulse, ignored while `busy`
- `num`  in  5  entries to run (0..DEPTH; >DEPTH clamps to DEPTH)
- `busy`  out  1  batch in progress
- `finished`  out  1  one-cycle pulse at batch end
- `err_cnt`  out  4  flagged entries in last batch, saturating at 15
- `rd_addr`  in  log2(DEPTH)  result read index
- `rd_x`  out  8  captured `x` (combinational read)
- `rd_y`  out  10  captured `y` (combinational read)
- `rd_flags`  out  2  {timeout, out_of_tol}
- `target`  out  10  to `SA`
- `start`  out  1  to `SA`, one-cycle pulse
- `done`  in  1  from `SA`
- `x`  in  8  from `SA`
- `y`  in  10  from `SA`

## Operation
- States: IDLE, LAUNCH, WAIT_DONE, WAIT_LOW, GAP, FINISH.
- IDLE: `run`=1 with effective num>0 → clear `err_cnt`, idx=0, go to LAUNCH. With num=0 → go to FINISH and issue no `start`.
- LAUNCH: `start`=1 and `target`=table[idx]. Go to WAIT_DONE and clear the timeout counter. `done` is not sampled in this state.
- WAIT_DONE: first cycle `done`=1 → write {x, y} and flags to result[idx], then go to WAIT_LOW. If the counter reaches `TIMEOUT` first → write x=0, y=0, timeout=1, then go to GAP.
- WAIT_LOW: stay until `done`=0, then go to GAP.
- GAP: count `GAP` cycles. Then, if idx==num−1, go to FINISH; otherwise idx+1 and go to LAUNCH.
- FINISH: `finished`=1 for one cycle, then go to IDLE.
- out_of_tol = |y − target| > TOL, computed as an 11-bit signed difference. It is never set together with timeout.
- `err_cnt` increments once per entry with any flag set and saturates at 15.
- `target` holds table[idx] from LAUNCH through the end of WAIT_LOW. It holds its last value in IDLE.
- Table writes during IDLE take effect at the next edge. A write in the same cycle as `run` is used by that batch.
- Results persist until overwritten by a later batch.

## Timing
- Reset values: `start`=0, `busy`=0, `finished`=0, `target`=0, `err_cnt`=0. All table and result entries are 0, so `rd_*`=0.
- Reset mid-batch returns to IDLE asynchronously; `start` drops immediately.
- `run` sampled at edge 0 → `start`=1 and `busy`=1 in cycle 1.
- `done` sampled high at edge k → result readable after edge k.
- `done` sampled low at edge m → next `start` at cycle m+GAP+1.
- `busy` is high from LAUNCH through FINISH inclusive.
- A `done` that stays high for many cycles produces one capture only.
- A `done` glitch during GAP or IDLE is ignored.

## Structure
- Package `sa_seq_pkg` holds:
  - the state enum
  - `TGT_W`=10, `X_W`=8
  - the flag bit indices `FLG_TO`=1 and `FLG_TOL`=0
- One sub-module, `sa_tol_check`: combinational |y − target| > TOL.
- Target table and result buffer are plain register arrays in the top module.

## Test plan
- Bench `SA` model returns y=target−2, x=target>>2 after 10 cycles, with `done` high for 2 cycles. Program table {550, 800}, num=2, `run` → two `start` pulses with `target`=550 then 800. Results: (137, 548) and (200, 798), flags 0, `err_cnt`=0, one `finished`.
- Model returns y=target+5 for 550 → entry 0 has out_of_tol=1 and `err_cnt`=1. A model returning y=target−4 gives no flag (boundary).
- Model never asserts `done` → `start` re-pulses after TIMEOUT+GAP cycles, result = (0, 0, timeout=1). With num=16 the batch still finishes and `err_cnt`=15 (saturated).
- num=0 → `finished` one cycle after `run`, no `start`. num=20 → exactly 8 searches.
- Assert `reset` low during WAIT_DONE → `start`, `busy`, `target` and `err_cnt` are 0 at once. After release, `run` works normally.
- `run` and `wr_en` while `busy` → no effect. `done` held high for 20 cycles → single capture, next `start` only after `done` falls plus GAP.
